// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default constants for the single-port memory arbiter.
// The instruction-fetch and data-stage requesters compete for one memory port.
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_LIM_DEF = 3;

    // MEM_LAT is at most 4, so the counter only has to hold MEM_LAT-1 (max 3).
    localparam int LAT_W    = 2;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-port signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_if;
    logic              stall_d;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output stall_if, stall_d
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  stall_if, stall_d
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and data-stage requests onto one memory port, one transaction in flight.
// Data stage has priority; IF is forced through after STARVE_LIM consecutive losses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
)(
    input  logic              clk1,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [LAT_W-1:0]    LAT_INIT     = LAT_W'(MEM_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM_V = STARVE_W'(STARVE_LIM);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    arb_owner_e            r_owner;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic                  r_drop;
    logic [STARVE_W-1:0]   r_starve;
    logic                  r_if_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_W-1:0]     r_if_rdata;
    logic [DATA_W-1:0]     r_d_rdata;

    logic                  w_force_if;
    logic                  w_d_win;
    logic                  w_if_win;
    logic                  w_rd_done;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Winner selection is gated by rst_n so every combinational output is 0 in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_force_if  = 1'b0;
        w_d_win     = 1'b0;
        w_if_win    = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n) begin
                    w_force_if = (r_starve == STARVE_LIM_V) && bus.if_req;
                    w_d_win    = bus.d_req && !w_force_if;
                    w_if_win   = bus.if_req && !w_d_win;
                    if (w_if_win || (w_d_win && !bus.d_we)) begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_IF;
            r_lat_cnt   <= '0;
            r_drop      <= 1'b0;
            r_starve    <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            if (r_state == IDLE) begin
                if (w_if_win) begin
                    r_owner   <= OWN_IF;
                    r_lat_cnt <= LAT_INIT;
                    r_drop    <= bus.if_flush;
                    r_starve  <= '0;
                end else if (w_d_win && !bus.d_we) begin
                    r_owner   <= OWN_D;
                    r_lat_cnt <= LAT_INIT;
                    r_drop    <= 1'b0;
                end
                if (w_d_win && bus.if_req && (r_starve != STARVE_LIM_V)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end else begin
                if (bus.if_flush) begin
                    r_drop <= 1'b1;
                end
                if (r_lat_cnt != '0) begin
                    r_lat_cnt <= r_lat_cnt - 1'b1;
                end
                // A flush in the capture cycle itself still kills an IF response.
                if (w_rd_done) begin
                    if (r_owner == OWN_D) begin
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= bus.mem_rdata;
                    end else if (!r_drop && !bus.if_flush) begin
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.if_gnt    = w_if_win;
    assign bus.d_gnt     = w_d_win;
    assign bus.mem_en    = w_if_win | w_d_win;
    assign bus.mem_we    = w_d_win & bus.d_we;
    assign bus.mem_addr  = w_d_win ? bus.d_addr : (w_if_win ? bus.if_addr : '0);
    assign bus.mem_wdata = w_d_win ? bus.d_wdata : '0;
    assign bus.stall_if  = rst_n & bus.if_req & ~w_if_win;
    assign bus.stall_d   = rst_n & bus.d_req & ~w_d_win;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.d_rdata   = r_d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 ADDR_W, 10, word address width for a 1024-word memory.
REQ-002 DATA_W, 32, data width.
REQ-003 MEM_LAT, 1, memory read latency in cycles; legal range 1..4.
REQ-004 STARVE_LIM, 3, consecutive IF losses that force an IF win; legal range 1..15.
REQ-005 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 clk1  in  1  sole clock; all state updates on posedge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 if_req / if_addr  in  1 / ADDR_W  instruction-fetch read request and address; held until grant.
REQ-009 if_flush  in  1  taken branch; discards any pending IF read response.
REQ-010 if_gnt / if_rvalid / if_rdata  out  1 / 1 / DATA_W  IF grant pulse, response valid pulse, response data.
REQ-011 d_req / d_we / d_addr / d_wdata  in  1 / 1 / ADDR_W / DATA_W  data-stage request; held until grant.
REQ-012 d_gnt / d_rvalid / d_rdata  out  1 / 1 / DATA_W  data grant pulse, read valid pulse, read data.
REQ-013 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  single memory port command.
REQ-014 mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after the mem_en cycle.
REQ-015 stall_if / stall_d  out  1 / 1  asserted as (req && !gnt) per requester; drive the PC and pipeline-register write enables.

Function
REQ-016 FSM states SHALL be IDLE and RD_WAIT; grants SHALL occur only in IDLE; at most one transaction outstanding.
REQ-017 Grants and mem_* outputs SHALL be combinational from the IDLE-cycle winner; with no request: mem_en=0 and mem_addr/mem_wdata=0.
REQ-018 Default priority SHALL be data-stage over IF.
REQ-019 starve_cnt SHALL increment, saturating at STARVE_LIM, on each IDLE cycle where both request and D wins; it SHALL clear when IF is granted.
REQ-020 When starve_cnt==STARVE_LIM and if_req=1, IF SHALL win.
REQ-021 A D write SHALL complete in its grant cycle: mem_we=1, no rvalid, state stays IDLE, next grant possible the following cycle.
REQ-022 A read granted in cycle N SHALL move to RD_WAIT; the owner and a latency counter are recorded; mem_rdata is sampled at the end of cycle N+MEM_LAT.
REQ-023 The owner rvalid/rdata SHALL be registered, high for exactly cycle N+MEM_LAT+1; state returns to IDLE in that same cycle, allowing a new grant.
REQ-024 Read throughput SHALL be one read per MEM_LAT+1 cycles; writes one per cycle.
REQ-025 If if_flush=1 in the IF grant cycle or any cycle up to N+MEM_LAT of an IF-owned read, if_rvalid SHALL be suppressed; the state SHALL still complete RD_WAIT.
REQ-026 if_flush SHALL have no effect on D transactions or on starve_cnt.
REQ-027 if_rdata/d_rdata SHALL hold their last value when rvalid=0.
REQ-028 Requests raised during RD_WAIT SHALL see gnt=0 and stall=1 until IDLE.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, starve_cnt=0, latency counter=0, drop flag=0, rvalid=0, rdata=0; an in-flight read is discarded.
REQ-030 Combinational outputs SHALL be 0 during reset regardless of requests.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state enum (IDLE, RD_WAIT), owner enum (OWN_IF, OWN_D) and default parameter constants.
REQ-032 The block SHALL be a single module; no sub-module.

Verification
REQ-033 MEM_LAT=1; if_req addr 5 alone in cycle 0 -> if_gnt cycle 0, mem_en/mem_addr=5 cycle 0, if_rvalid with mem_rdata value in cycle 2.
REQ-034 Both requesters every cycle, D writes -> D granted cycles 0,1,2; IF granted cycle 3 (STARVE_LIM=3); starve_cnt back to 0.
REQ-035 D write addr 7 data 0xDEADBEEF then D read addr 7 -> mem_we=1 cycle 0; read granted cycle 1; d_rvalid cycle 3 returns 0xDEADBEEF.
REQ-036 IF read granted cycle 0, if_flush=1 cycle 1, MEM_LAT=2 -> no if_rvalid; IDLE reached cycle 3; pending d_req granted cycle 3.
REQ-037 rst_n low in cycle 1 of a RD_WAIT read -> no rvalid ever, state IDLE, next request granted the first cycle after release.
REQ-038 MEM_LAT=4, back-to-back D reads -> grants every 5 cycles; stall_d high between grants.
